stopwatch_timer_core: RTL and testbench
=======================================

Name: stopwatch_timer_core

Overview:
Four-digit MM:SS stopwatch/countdown timer with an integrated tick prescaler, start/stop FSM, lap-hold and preset load. It drives four 7-segment digit outputs. It is the parametrised successor of the board-level timer: clock frequency, tick rate and segment polarity are configurable, and it adds count-down mode with a done flag. It sits between the debounced button/switch inputs and the display mux.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
TICK_FREQ, 1, count-tick rate in Hz; prescaler divides by CLK_FREQ/TICK_FREQ (must be integer >= 2)
SEG_ACTIVE_LOW, 0, 1 = segment outputs inverted (common-anode)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start_stop  input  1  debounced level; rising edge toggles run/pause
clear  input  1  synchronous clear of count and FSM to IDLE
lap  input  1  debounced level; rising edge toggles display freeze
mode_down  input  1  0 = count up, 1 = count down; sampled only in IDLE
load  input  1  1-cycle strobe; loads preset (IDLE/PAUSE only)
preset  input  16  BCD {min_t, min_u, sec_t, sec_u}
seg_min_t  output  7  segments {g,f,e,d,c,b,a}, minutes tens
seg_min_u  output  7  minutes units
seg_sec_t  output  7  seconds tens
seg_sec_u  output  7  seconds units
running  output  1  high in RUN
done  output  1  high in DONE (count-down reached 00:00)
wrap  output  1  1-cycle pulse when count-up wraps 59:59 -> 00:00

Behaviour:
- Reset (async, active-high): digits 00:00, prescaler 0, FSM IDLE, lap released, down mode cleared, edge-detect registers 0. Segments show "0" on all digits (7'b0111111, inverted if SEG_ACTIVE_LOW). running, done and wrap are all 0.
- Edge detect: start_stop and lap are registered. An event is prev=0, cur=1, so one event occurs per press.
- Prescaler: counts 0..CLK_FREQ/TICK_FREQ-1 only in RUN. It generates a 1-cycle tick at terminal count, then wraps. It holds its value in PAUSE and is zeroed on clear, load and entry to RUN from IDLE.
- FSM states:
  - IDLE: a start_stop event latches mode_down and goes to RUN. In down mode with count 00:00, it goes straight to DONE.
  - RUN: a start_stop event goes to PAUSE. A down-mode tick taking the count to 00:00 goes to DONE in the same cycle the digits become 00:00.
  - PAUSE: a start_stop event goes to RUN.
  - DONE: holds 00:00. A start_stop event is ignored. clear goes to IDLE.
- Counting (per tick):
  - Up: BCD cascade sec_u 0-9, sec_t 0-5, min_u 0-9, min_t 0-5. 59:59 -> 00:00 with a wrap pulse in that cycle; counting continues.
  - Down: inverse cascade with borrow. 00:01 -> 00:00 enters DONE. Digits never go below 0 or above their limits.
- Priority within a cycle: clear > load > start_stop event > tick.
  - A tick coincident with a start_stop event that pauses: the tick is applied and the state becomes PAUSE.
- Load: in IDLE/PAUSE only; ignored in RUN/DONE. Any preset digit above its limit (sec_t/min_t > 5, units > 9) is saturated to the limit.
- Lap: an event toggles lap_hold. While held, the display registers keep the digits captured at the event cycle; the count continues internally. clear or reset releases the hold.
- Segment outputs are registered: 1-cycle latency from digit (or display-latch) change to segment change. BCD-to-7seg decode is standard for 0-9.
- running, done and wrap are registered and change in the same cycle as the state or count.

Optional Feature:
PAUSE_BLINK_EN
- Defined: in PAUSE, all four digits blank (all segments off, honouring SEG_ACTIVE_LOW) during alternate half-periods of a free-running divider of period CLK_FREQ/2 cycles. The divider is cleared on PAUSE entry so the first half-period shows the digits. Blinking is suppressed while lap_hold is active.
- Undefined: PAUSE shows the digits steadily; no divider logic is instantiated.

Test Plan:
1. CLK_FREQ=10, TICK_FREQ=1: reset, start_stop event, run 600 cycles -> display 01:00 (segments 0,1,0,0 one cycle after the 60th tick); running=1.
2. Load preset 16'h5958 in IDLE, start up-count, 2 ticks -> 00:00 after the 2nd tick with a single 1-cycle wrap pulse; counting continues to 00:01.
3. mode_down=1, load 16'h0003, start -> 00:02, 00:01, 00:00 on successive ticks; done=1 and running=0 at the 00:00 cycle; a further start_stop event leaves DONE and 00:00; clear -> IDLE, done=0.
4. Running at 00:05: lap event -> display frozen at 00:05 for 3 ticks while internal count reaches 00:08; second lap event -> display 00:08 one cycle later.
5. Simultaneous clear + start_stop event + tick in RUN at 00:09 -> IDLE, 00:00, running=0; load 16'h7A9F in PAUSE -> saturates to 59:59.
6. Assert reset mid-RUN at 12:34, between clock edges -> outputs immediately 00:00 and running=0; after release the FSM is in IDLE and needs a new start_stop event to count.

Source files
------------

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: MM:SS up/down stopwatch with tick prescaler, lap hold and preset load; define PAUSE_BLINK_EN to blink digits while paused
module stopwatch_timer_core #(
  parameter int CLK_FREQ       = 50000000,
  parameter int TICK_FREQ      = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  input  logic        mode_down,
  input  logic        load,
  input  logic [15:0] preset,
  output logic [6:0]  seg_min_t,
  output logic [6:0]  seg_min_u,
  output logic [6:0]  seg_sec_t,
  output logic [6:0]  seg_sec_u,
  output logic        running,
  output logic        done,
  output logic        wrap
);
  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int PW = $clog2(DIV);
  localparam logic [6:0] INV = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
  localparam logic [6:0] LUT [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                      7'h7f, 7'h6f, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, disp_q, disp_d, inc, dec, sat, view;
  logic [PW-1:0] pre_q, pre_d;
  logic [27:0] seg_q, seg_d;
  logic ss_q, lap_q, down_q, down_d, hold_q, hold_d;
  logic wrap_q, wrap_d, running_q, done_q;
  logic tick, ss_ev, lap_ev, blank, c0, c1, c2, b0, b1, b2;

  assign ss_ev  = start_stop & ~ss_q;
  assign lap_ev = lap & ~lap_q;
  assign view   = hold_q ? disp_q : cnt_q;

  assign c0 = cnt_q[3:0] == 4'd9;
  assign c1 = c0 && cnt_q[7:4] == 4'd5;
  assign c2 = c1 && cnt_q[11:8] == 4'd9;
  assign inc = {c2 ? (cnt_q[15:12] == 4'd5 ? 4'd0 : cnt_q[15:12] + 4'd1) : cnt_q[15:12],
                c1 ? (c2 ? 4'd0 : cnt_q[11:8] + 4'd1) : cnt_q[11:8],
                c0 ? (c1 ? 4'd0 : cnt_q[7:4] + 4'd1) : cnt_q[7:4],
                c0 ? 4'd0 : cnt_q[3:0] + 4'd1};

  assign b0 = cnt_q[3:0] == 4'd0;
  assign b1 = b0 && cnt_q[7:4] == 4'd0;
  assign b2 = b1 && cnt_q[11:8] == 4'd0;
  assign dec = {b2 ? cnt_q[15:12] - 4'd1 : cnt_q[15:12],
                b1 ? (b2 ? 4'd9 : cnt_q[11:8] - 4'd1) : cnt_q[11:8],
                b0 ? (b1 ? 4'd5 : cnt_q[7:4] - 4'd1) : cnt_q[7:4],
                b0 ? 4'd9 : cnt_q[3:0] - 4'd1};

  assign sat = {preset[15:12] > 4'd5 ? 4'd5 : preset[15:12],
                preset[11:8] > 4'd9 ? 4'd9 : preset[11:8],
                preset[7:4] > 4'd5 ? 4'd5 : preset[7:4],
                preset[3:0] > 4'd9 ? 4'd9 : preset[3:0]};

`ifdef PAUSE_BLINK_EN
  localparam int BP = CLK_FREQ / 2;
  localparam int BW = BP > 1 ? $clog2(BP) : 1;
  logic [BW-1:0] bk_q, bk_d;
  // blink divider restarts on PAUSE entry so the first half-period shows digits
  always_comb bk_d = (state_d == PAUSE && state_q != PAUSE) || bk_q == BW'(BP - 1) ? '0 : bk_q + BW'(1);
  // blink divider register
  always_ff @(posedge clk or posedge reset)
    if (reset) bk_q <= '0;
    else bk_q <= bk_d;
  assign blank = state_q == PAUSE && !hold_q && bk_q >= BW'(BP / 2);
`else
  assign blank = 1'b0;
`endif

  // next state: clear > load > start_stop event > tick, plus lap latch and segment decode
  always_comb begin
    tick = state_q == RUN && pre_q == PW'(DIV - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    pre_d = state_q == RUN ? (tick ? '0 : pre_q + PW'(1)) : pre_q;
    down_d = down_q;
    hold_d = lap_ev ? ~hold_q : hold_q;
    disp_d = lap_ev ? cnt_q : disp_q;
    wrap_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d = '0;
      pre_d = '0;
      hold_d = 1'b0;
    end else if (load && (state_q == IDLE || state_q == PAUSE)) begin
      cnt_d = sat;
      pre_d = '0;
    end else begin
      if (tick) begin
        cnt_d = down_q ? (cnt_q == '0 ? cnt_q : dec) : inc;
        wrap_d = !down_q && c2 && cnt_q[15:12] == 4'd5;
        state_d = down_q && (cnt_q == 16'h0001 || cnt_q == '0) ? DONE : state_q;
      end
      if (ss_ev && state_q == RUN && state_d != DONE) state_d = PAUSE;
      if (ss_ev && state_q == PAUSE) state_d = RUN;
      if (ss_ev && state_q == IDLE) begin
        down_d = mode_down;
        pre_d = '0;
        state_d = mode_down && cnt_q == '0 ? DONE : RUN;
      end
    end
    seg_d = blank ? {4{INV}} : {LUT[view[15:12]] ^ INV, LUT[view[11:8]] ^ INV,
                                LUT[view[7:4]] ^ INV, LUT[view[3:0]] ^ INV};
  end

  // all state and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      disp_q <= '0;
      pre_q <= '0;
      ss_q <= 1'b0;
      lap_q <= 1'b0;
      down_q <= 1'b0;
      hold_q <= 1'b0;
      wrap_q <= 1'b0;
      running_q <= 1'b0;
      done_q <= 1'b0;
      seg_q <= {4{LUT[0] ^ INV}};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      disp_q <= disp_d;
      pre_q <= pre_d;
      ss_q <= start_stop;
      lap_q <= lap;
      down_q <= down_d;
      hold_q <= hold_d;
      wrap_q <= wrap_d;
      running_q <= state_d == RUN;
      done_q <= state_d == DONE;
      seg_q <= seg_d;
    end

  assign {seg_min_t, seg_min_u, seg_sec_t, seg_sec_u} = seg_q;
  assign running = running_q;
  assign done = done_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// tb_stopwatch_timer_core: directed, table-driven and randomized checks against a seconds-based reference model
module tb_stopwatch_timer_core;
  localparam int DIVN = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic clk, reset, start_stop, clear, lap, mode_down, load;
  logic [15:0] preset;
  logic [6:0] seg_min_t, seg_min_u, seg_sec_t, seg_sec_u;
  logic running, done, wrap;
  logic [27:0] seg_all;
  int total, bad;
  int m_st, m_t, m_pre, m_disp;
  bit m_down, m_hold, m_ssp, m_lapp;
  logic [27:0] e_seg;
  logic e_run, e_done, e_wrap;

  typedef struct { logic [15:0] preset; logic [15:0] shown; } vec_t;
  vec_t vt [8];

  stopwatch_timer_core #(.CLK_FREQ(10), .TICK_FREQ(1), .SEG_ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .mode_down(mode_down), .load(load), .preset(preset),
    .seg_min_t(seg_min_t), .seg_min_u(seg_min_u), .seg_sec_t(seg_sec_t), .seg_sec_u(seg_sec_u),
    .running(running), .done(done), .wrap(wrap));

  assign seg_all = {seg_min_t, seg_min_u, seg_sec_t, seg_sec_u};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] d);
    logic [6:0] p [10];
    p = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
    return d < 10 ? p[d] : 7'h00;
  endfunction

  function automatic logic [27:0] segs(input logic [15:0] b);
    return {pat(b[15:12]), pat(b[11:8]), pat(b[7:4]), pat(b[3:0])};
  endfunction

  function automatic logic [15:0] tobcd(input int t);
    return {4'(t / 600), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'(t % 10)};
  endfunction

  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction

  function automatic int satval(input logic [15:0] p);
    return mn(int'(p[15:12]), 5) * 600 + mn(int'(p[11:8]), 9) * 60 + mn(int'(p[7:4]), 5) * 10 + mn(int'(p[3:0]), 9);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_t = 0; m_pre = 0; m_disp = 0;
    m_down = 0; m_hold = 0; m_ssp = 0; m_lapp = 0;
    e_seg = segs(16'h0000); e_run = 0; e_done = 0; e_wrap = 0;
  endtask

  task automatic model_step();
    bit ssev, lev, tk, nhold, ndown, nwrap;
    int nst, nt, npre, ndisp;
    ssev = start_stop && !m_ssp;
    lev = lap && !m_lapp;
    tk = m_st == M_RUN && m_pre == DIVN - 1;
    npre = m_st == M_RUN ? (tk ? 0 : m_pre + 1) : m_pre;
    nst = m_st; nt = m_t; ndown = m_down; nwrap = 0;
    nhold = lev ? !m_hold : m_hold;
    ndisp = lev ? m_t : m_disp;
    if (clear) begin
      nst = M_IDLE; nt = 0; npre = 0; nhold = 0;
    end else if (load && (m_st == M_IDLE || m_st == M_PAUSE)) begin
      nt = satval(preset); npre = 0;
    end else begin
      if (tk) begin
        if (m_down) begin
          nt = m_t > 0 ? m_t - 1 : 0;
          if (nt == 0) nst = M_DONE;
        end else begin
          nwrap = m_t == 3599;
          nt = (m_t + 1) % 3600;
        end
      end
      if (ssev) begin
        if (m_st == M_RUN && nst != M_DONE) nst = M_PAUSE;
        else if (m_st == M_PAUSE) nst = M_RUN;
        else if (m_st == M_IDLE) begin
          ndown = mode_down; npre = 0;
          nst = (mode_down && m_t == 0) ? M_DONE : M_RUN;
        end
      end
    end
    e_seg = segs(tobcd(m_hold ? m_disp : m_t));
    e_run = nst == M_RUN; e_done = nst == M_DONE; e_wrap = nwrap;
    m_st = nst; m_t = nt; m_pre = npre; m_down = ndown; m_hold = nhold; m_disp = ndisp;
    m_ssp = start_stop; m_lapp = lap;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("model", {seg_all, running, done, wrap}, {e_seg, e_run, e_done, e_wrap});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ss_pulse();
    start_stop = 1; step(); start_stop = 0;
  endtask

  task automatic do_load(input logic [15:0] p);
    load = 1; preset = p; step(); load = 0;
  endtask

  task automatic do_clear();
    clear = 1; step(); clear = 0;
  endtask

  initial begin
    int wraps;
    vt[0] = '{16'h0000, 16'h0000}; vt[1] = '{16'h1234, 16'h1234};
    vt[2] = '{16'h5959, 16'h5959}; vt[3] = '{16'h7A9F, 16'h5959};
    vt[4] = '{16'h0607, 16'h0607}; vt[5] = '{16'hF0F0, 16'h5050};
    vt[6] = '{16'h4185, 16'h4155}; vt[7] = '{16'h2468, 16'h2458};
    total = 0; bad = 0;
    reset = 1; start_stop = 0; clear = 0; lap = 0; mode_down = 0; load = 0; preset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_seg", seg_all, segs(16'h0000));
    chk("reset_flags", {running, done, wrap}, 3'b000);
    reset = 0;
    // count up 60 seconds
    ss_pulse();
    steps(600);
    chk("t1_0059", seg_all, segs(16'h0059));
    step();
    chk("t1_0100", seg_all, segs(16'h0100));
    chk("t1_running", running, 1);
    // wrap from 59:58
    do_clear();
    do_load(16'h5958);
    ss_pulse();
    wraps = 0;
    for (int i = 0; i < 21; i++) begin
      step();
      if (wrap) wraps++;
    end
    chk("t2_wrap_count", wraps, 1);
    chk("t2_0000", seg_all, segs(16'h0000));
    steps(10);
    chk("t2_0001", seg_all, segs(16'h0001));
    // count down to done
    do_clear();
    mode_down = 1;
    do_load(16'h0003);
    ss_pulse();
    steps(11);
    chk("t3_0002", seg_all, segs(16'h0002));
    steps(10);
    chk("t3_0001", seg_all, segs(16'h0001));
    chk("t3_run_before", {running, done}, 2'b10);
    steps(9);
    chk("t3_done_flags", {running, done}, 2'b01);
    step();
    chk("t3_0000", seg_all, segs(16'h0000));
    ss_pulse();
    step();
    chk("t3_done_holds", {seg_all, running, done}, {segs(16'h0000), 2'b01});
    do_clear();
    chk("t3_cleared", {running, done}, 2'b00);
    mode_down = 0;
    // lap freeze and release
    do_clear();
    do_load(16'h0005);
    ss_pulse();
    lap = 1; step(); lap = 0;
    steps(29);
    chk("t4_frozen", seg_all, segs(16'h0005));
    lap = 1; step(); lap = 0;
    chk("t4_release_lag", seg_all, segs(16'h0005));
    step();
    chk("t4_0008", seg_all, segs(16'h0008));
    // clear beats start_stop and tick; saturated load in PAUSE
    do_clear();
    do_load(16'h0009);
    ss_pulse();
    steps(9);
    clear = 1; start_stop = 1; step(); clear = 0; start_stop = 0;
    chk("t5_running", running, 0);
    step();
    chk("t5_0000", seg_all, segs(16'h0000));
    steps(15);
    chk("t5_idle", {seg_all, running}, {segs(16'h0000), 1'b0});
    ss_pulse(); step(); ss_pulse();
    chk("t5_paused", running, 0);
    do_load(16'h7A9F);
    step();
    chk("t5_sat", seg_all, segs(16'h5959));
    steps(12);
    chk("t5_pause_hold", seg_all, segs(16'h5959));
    // saturating load table in IDLE
    do_clear();
    for (int i = 0; i < 8; i++) begin
      do_load(vt[i].preset);
      step();
      chk("load_tbl", seg_all, segs(vt[i].shown));
    end
    // asynchronous reset mid-run
    do_clear();
    do_load(16'h1234);
    ss_pulse();
    steps(5);
    #2 reset = 1;
    #1;
    chk("t6_async_seg", seg_all, segs(16'h0000));
    chk("t6_async_run", running, 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    steps(25);
    chk("t6_idle", {seg_all, running}, {segs(16'h0000), 1'b0});
    ss_pulse();
    steps(11);
    chk("t6_restart", {seg_all, running}, {segs(16'h0001), 1'b1});
    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 40) == 0) lap = ~lap;
      clear = $urandom_range(0, 200) == 0;
      load = $urandom_range(0, 40) == 0;
      preset = $urandom_range(0, 2) == 0 ? 16'h5955 : 16'($urandom);
      mode_down = $urandom_range(0, 1) == 1;
      step();
    end
    start_stop = 0; lap = 0; clear = 0; load = 0; mode_down = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
